// File: rtl/alu_result_fifo.sv
// First-word-fall-through FIFO for ALU {result, status} words with sticky overflow and a saturating error counter.
// Define ALU_ERR_DROP_EN to count error-status pushes without storing them.
module alu_result_fifo #(
    parameter int M     = 4,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_valid,
    input  logic [M-1:0]     i_result,
    input  logic [3:0]       i_status,
    output logic             o_in_ready,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [M-1:0]     o_result,
    output logic [3:0]       o_status,
    output logic             o_empty,
    output logic             o_full,
    output logic             o_overflow,
    output logic [CNT_W-1:0] o_err_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [M+3:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [M+3:0]  head;
    logic          push;
    logic          pop;
    logic          wr_en;

    assign o_empty    = (count == '0);
    assign o_full     = (count == FULL_CNT);
    assign o_in_ready = !o_full;
    assign o_valid    = !o_empty;

    assign push = i_valid && o_in_ready;
    assign pop  = o_valid && i_ready;

`ifdef ALU_ERR_DROP_EN
    assign wr_en = push && !i_status[3];
`else
    assign wr_en = push;
`endif

    // Head is read straight from storage and forced to zero while empty.
    assign head     = mem[rd_ptr];
    assign o_result = o_empty ? '0 : head[M+3:4];
    assign o_status = o_empty ? '0 : head[3:0];

    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= {i_result, i_status};
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_en, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Errors are counted on the accepted handshake, even when the entry itself is dropped.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            o_overflow  <= 1'b0;
            o_err_count <= '0;
        end else begin
            if (i_valid && o_full) begin
                o_overflow <= 1'b1;
            end
            if (push && i_status[3] && (o_err_count != '1)) begin
                o_err_count <= o_err_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_alu_result_fifo.sv
// Scoreboard bench for alu_result_fifo: directed pushes queue expected entries, a negedge monitor checks every pop.
module tb_alu_result_fifo;

`ifdef ALU_ERR_DROP_EN
    localparam bit DROP = 1'b1;
`else
    localparam bit DROP = 1'b0;
`endif

    typedef struct {
        logic [3:0] r;
        logic [3:0] s;
    } ent_t;

    logic       clk;
    logic       rst_n;
    logic       i_valid;
    logic [3:0] i_result;
    logic [3:0] i_status;
    logic       o_in_ready;
    logic       o_valid;
    logic       i_ready;
    logic [3:0] o_result;
    logic [3:0] o_status;
    logic       o_empty;
    logic       o_full;
    logic       o_overflow;
    logic [1:0] o_err_count;

    ent_t q[$];
    int   checks = 0;
    int   fails  = 0;

    alu_result_fifo #(.M(4), .DEPTH(4), .CNT_W(2)) dut (
        .i_clk       (clk),
        .i_reset     (rst_n),
        .i_valid     (i_valid),
        .i_result    (i_result),
        .i_status    (i_status),
        .o_in_ready  (o_in_ready),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_result    (o_result),
        .o_status    (o_status),
        .o_empty     (o_empty),
        .o_full      (o_full),
        .o_overflow  (o_overflow),
        .o_err_count (o_err_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_output(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle push; accepted entries that are not dropped join the scoreboard.
    task automatic apply_stimulus(input logic [3:0] r, input logic [3:0] s, input bit accept);
        ent_t e;
        i_valid  = 1'b1;
        i_result = r;
        i_status = s;
        if (accept && !(DROP && s[3])) begin
            e.r = r;
            e.s = s;
            q.push_back(e);
        end
        tick();
        i_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        q.delete();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    always @(negedge clk) begin
        if (rst_n && o_valid && i_ready) begin
            if (q.size() == 0) begin
                check_output("unexpected_pop", 1, 0);
            end else begin
                ent_t e;
                e = q.pop_front();
                check_output("pop_result", int'(o_result), int'(e.r));
                check_output("pop_status", int'(o_status), int'(e.s));
            end
        end
    end

    initial begin
        rst_n    = 1'b0;
        i_valid  = 1'b0;
        i_ready  = 1'b0;
        i_result = '0;
        i_status = '0;
        tick();
        check_output("rst_empty", int'(o_empty), 1);
        check_output("rst_full", int'(o_full), 0);
        check_output("rst_valid", int'(o_valid), 0);
        check_output("rst_in_ready", int'(o_in_ready), 1);
        check_output("rst_err", int'(o_err_count), 0);
        check_output("rst_result_zero", int'(o_result), 0);
        rst_n = 1'b1;
        tick();

        // FIFO order and one-cycle fall-through latency
        apply_stimulus(4'b0011, 4'b0110, 1'b1);
        check_output("latency_valid", int'(o_valid), 1);
        check_output("latency_head", int'(o_result), 3);
        apply_stimulus(4'b1001, 4'b0100, 1'b1);
        check_output("order_head_held", int'(o_result), 3);
        i_ready = 1'b1;
        tick();
        tick();
        i_ready = 1'b0;
        check_output("order_empty", int'(o_empty), 1);
        check_output("order_status_zero", int'(o_status), 0);

        // Fill, overflow, and no pass-through when full
        apply_stimulus(4'd1, 4'd0, 1'b1);
        apply_stimulus(4'd2, 4'd0, 1'b1);
        apply_stimulus(4'd4, 4'd0, 1'b1);
        apply_stimulus(4'd8, 4'd0, 1'b1);
        check_output("full_flag", int'(o_full), 1);
        check_output("full_in_ready", int'(o_in_ready), 0);
        check_output("ovf_before", int'(o_overflow), 0);
        apply_stimulus(4'b0101, 4'b0100, 1'b0);
        check_output("ovf_set", int'(o_overflow), 1);
        check_output("ovf_still_full", int'(o_full), 1);
        check_output("ovf_head", int'(o_result), 1);
        i_ready = 1'b1;
        apply_stimulus(4'd7, 4'd0, 1'b0);
        i_ready = 1'b0;
        check_output("full_pop_no_push", int'(o_full), 0);
        check_output("full_pop_head", int'(o_result), 2);
        i_ready = 1'b1;
        tick();
        tick();
        tick();
        i_ready = 1'b0;
        check_output("drain_empty", int'(o_empty), 1);
        check_output("ovf_sticky", int'(o_overflow), 1);

        // Asynchronous reset with entries held
        apply_stimulus(4'd10, 4'd1, 1'b1);
        apply_stimulus(4'd12, 4'd2, 1'b1);
        rst_n = 1'b0;
        #1;
        check_output("async_empty", int'(o_empty), 1);
        check_output("async_valid", int'(o_valid), 0);
        check_output("async_err", int'(o_err_count), 0);
        check_output("async_ovf", int'(o_overflow), 0);
        q.delete();
        tick();
        rst_n = 1'b1;
        tick();

        // Error status push
        apply_stimulus(4'b0000, 4'b1001, 1'b1);
        check_output("err_count_1", int'(o_err_count), 1);
        if (DROP) begin
            check_output("err_dropped_empty", int'(o_empty), 1);
        end else begin
            check_output("err_stored_valid", int'(o_valid), 1);
            check_output("err_stored_status", int'(o_status), 9);
        end
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        check_output("err_drain_empty", int'(o_empty), 1);

        // Simultaneous push and pop at occupancy 2
        apply_stimulus(4'd1, 4'd0, 1'b1);
        apply_stimulus(4'd2, 4'd0, 1'b1);
        i_ready = 1'b1;
        apply_stimulus(4'b0110, 4'b0100, 1'b1);
        tick();
        i_ready = 1'b0;
        check_output("conc_third_valid", int'(o_valid), 1);
        check_output("conc_third_result", int'(o_result), 6);
        check_output("conc_third_status", int'(o_status), 4);
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        check_output("conc_empty", int'(o_empty), 1);

        // Error counter saturation with CNT_W=2
        pulse_reset();
        i_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            apply_stimulus(4'(k), 4'b1000, 1'b1);
            check_output("sat_err_count", int'(o_err_count), (k + 1 < 3) ? k + 1 : 3);
        end
        tick();
        i_ready = 1'b0;
        check_output("sat_empty", int'(o_empty), 1);

        tick();
        check_output("scoreboard_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/alu_result_fifo.md
ALU_RESULT_FIFO -- requirements
Module: alu_result_fifo

Interface
REQ-001 The block SHALL have parameter M, default 4, giving the ALU result width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 4, giving the entry count; it SHALL be a power of two and at least 2.
REQ-003 The block SHALL have parameter CNT_W, default 8, giving the error-counter width.
REQ-004 The block SHALL have port i_clk, input, 1 bit, the single clock; all state SHALL change on its rising edge.
REQ-005 The block SHALL have port i_reset, input, 1 bit, reset; one clock, reset asynchronous and active-low.
REQ-006 The block SHALL have port i_valid, input, 1 bit, marking an ALU result offered this cycle.
REQ-007 The block SHALL have port i_result, input, M bits, the ALU result word.
REQ-008 The block SHALL have port i_status, input, 4 bits, the ALU status; bit 3 is the error flag.
REQ-009 The block SHALL have port o_in_ready, output, 1 bit, high when a push is accepted.
REQ-010 The block SHALL have port o_valid, output, 1 bit, high when a head entry is available.
REQ-011 The block SHALL have port i_ready, input, 1 bit, consumer accepts the head entry.
REQ-012 The block SHALL have port o_result, output, M bits, the head result.
REQ-013 The block SHALL have port o_status, output, 4 bits, the head status.
REQ-014 The block SHALL have ports o_empty and o_full, output, 1 bit each, occupancy flags.
REQ-015 The block SHALL have port o_overflow, output, 1 bit, sticky dropped-push flag.
REQ-016 The block SHALL have port o_err_count, output, CNT_W bits, count of accepted error statuses.

Function
REQ-017 Storage SHALL be a circular buffer of DEPTH entries of {i_result, i_status}, with write and read pointers and an occupancy counter of log2(DEPTH)+1 bits.
REQ-018 o_in_ready SHALL equal !o_full; a push occurs when i_valid && o_in_ready at a rising edge.
REQ-019 A pop SHALL occur when o_valid && i_ready at a rising edge; o_valid SHALL equal !o_empty.
REQ-020 The head SHALL be first-word-fall-through: o_result/o_status show the oldest entry combinationally from storage, with no read latency.
REQ-021 Write-to-o_valid latency SHALL be exactly one cycle from an accepted push into an empty buffer.
REQ-022 A simultaneous push and pop SHALL leave occupancy unchanged and preserve FIFO order.
REQ-023 When full, a push SHALL be refused even if a pop occurs in the same cycle; there is no full pass-through.
REQ-024 i_valid while o_full SHALL drop the entry and set o_overflow, which SHALL hold until reset.
REQ-025 Pointers SHALL wrap from DEPTH-1 to 0.
REQ-026 o_result/o_status while o_empty SHALL be all zeros.
REQ-027 Each accepted push with i_status[3]=1 SHALL increment o_err_count by one, saturating at 2^CNT_W-1.

Reset
REQ-028 On i_reset low, asynchronously: pointers, occupancy, o_overflow and o_err_count SHALL be 0, so o_empty=1, o_full=0, o_valid=0, o_in_ready=1.
REQ-029 A reset asserted mid-operation SHALL discard all stored entries; storage contents need not be cleared.
REQ-030 Release of i_reset SHALL take effect at the next rising edge of i_clk; no push is accepted in the release cycle's preceding edge.

Configuration
REQ-031 With macro ALU_ERR_DROP_EN defined, a push with i_status[3]=1 SHALL update o_err_count but SHALL NOT be written, and occupancy SHALL be unchanged.
REQ-032 Without ALU_ERR_DROP_EN, error-status pushes SHALL be stored like any other entry and still counted.

Verification
REQ-033 Reset: drive i_reset=0 with 2 entries held -> o_empty=1, o_valid=0, o_err_count=0, o_overflow=0 immediately, without a clock edge.
REQ-034 Order: push {0011,0110} then {1001,0100} with i_ready=0, then i_ready=1 -> head 0011/0110 for one pop, then 1001/0100, then o_empty=1.
REQ-035 Overflow: DEPTH=4, push 4 entries then {0101,0100} -> o_in_ready=0, o_overflow=1, occupancy 4, head unchanged.
REQ-036 Error: push {0000,1001} -> o_err_count=1; with ALU_ERR_DROP_EN o_empty stays 1, without it o_valid=1 with head 0000/1001.
REQ-037 Concurrency: at occupancy 2 push {0110,0100} while popping -> occupancy 2, new entry emerges third.
REQ-038 Saturation: CNT_W=2, push 5 error statuses with pops -> o_err_count reaches 3 and stays 3.
